load_store_unit: RTL and testbench

- Sits directly upstream of the unified byte-addressed memory's data port; the core's execute stage feeds it.
- Accepts one load or store request at a time over a valid/ready handshake.
- Converts byte, halfword and word accesses into the memory's fixed 32-bit read/write interface:
  - sub-word stores use read-modify-write, because the memory always writes 4 bytes;
  - loads are sign- or zero-extended.
- Returns one response pulse per request.

---
 rtl/lsu_pkg.sv | 7 +
 rtl/lsu_align.sv | 22 ++
 rtl/load_store_unit.sv | 77 +++++++
 tb/tb_load_store_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size/state types and sub-word widths for the load/store unit
package lsu_pkg;
   typedef enum logic [1:0] {SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10, SIZE_ILL = 2'b11} size_t;
   typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_t;
   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: load extension and sub-word store merge for a 32-bit memory word
module lsu_align
   import lsu_pkg::*;
(
   input  logic  [31:0] rdata,
   input  size_t        size,
   input  logic         uns,
   input  logic  [31:0] wdata,
   output logic  [31:0] ext,
   output logic  [31:0] merged
);
   function automatic logic [31:0] extend(input logic [31:0] d, input size_t s, input logic u);
      return s == SIZE_B ? {{(32-BYTE_W){!u && d[BYTE_W-1]}}, d[BYTE_W-1:0]} :
             s == SIZE_H ? {{(32-HALF_W){!u && d[HALF_W-1]}}, d[HALF_W-1:0]} : d;
   endfunction
   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input size_t s);
      return s == SIZE_B ? {o[31:BYTE_W], w[BYTE_W-1:0]} :
             s == SIZE_H ? {o[31:HALF_W], w[HALF_W-1:0]} : w;
   endfunction
   assign ext    = extend(rdata, size, uns);
   assign merged = merge(rdata, wdata, size);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for a 32-bit word-write memory
module load_store_unit
   import lsu_pkg::*;
#(
   parameter bit ALLOW_MISALIGNED = 1'b1,
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [31:0]       req_wdata_i,
   output logic              resp_valid_o,
   output logic [31:0]       resp_rdata_o,
   output logic              resp_err_o,
   output logic [ADDR_W-1:0] mem_data_addr_o,
   output logic [31:0]       mem_data_wdata_o,
   input  logic [31:0]       mem_data_rdata_i,
   output logic              mem_write_o
);
   state_t      state, state_nx;
   size_t       size;
   logic        uns, accept, err;
   logic [31:0] wdata, ext, merged;
   assign req_ready_o  = state == IDLE;
   assign resp_valid_o = state == RESP;
   assign mem_write_o  = state == WRITE;
   assign accept       = req_valid_i && req_ready_o;
   assign err = req_size_i == SIZE_ILL ||
                (!ALLOW_MISALIGNED && ((req_size_i == SIZE_H && req_addr_i[0]) ||
                                       (req_size_i == SIZE_W && req_addr_i[1:0] != 2'b00)));
   always_comb begin
      state_nx = state;
      state_nx = state == IDLE  ? (!accept ? IDLE : err ? RESP : !req_we_i ? LOAD :
                                   req_size_i == SIZE_W ? WRITE : MERGE) :
                 state == MERGE ? WRITE :
                 state == LOAD || state == WRITE ? RESP : IDLE;
   end
   lsu_align u_align (
      .rdata  (mem_data_rdata_i),
      .size   (size),
      .uns    (uns),
      .wdata  (wdata),
      .ext    (ext),
      .merged (merged)
   );
   // the memory only writes full words, so sub-word stores latch the merged word during MERGE
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state            <= IDLE;
         size             <= SIZE_B;
         uns              <= 1'b0;
         wdata            <= '0;
         resp_rdata_o     <= '0;
         resp_err_o       <= 1'b0;
         mem_data_addr_o  <= '0;
         mem_data_wdata_o <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            size         <= size_t'(req_size_i);
            uns          <= req_unsigned_i;
            wdata        <= req_wdata_i;
            resp_rdata_o <= '0;
            resp_err_o   <= err;
            if (!err) mem_data_addr_o <= req_addr_i;
            if (!err && req_we_i && req_size_i == SIZE_W) mem_data_wdata_o <= req_wdata_i;
         end
         if (state == LOAD) resp_rdata_o <= ext;
         if (state == MERGE) mem_data_wdata_o <= merged;
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed transactions on misaligned-allowed (0) and strict (1) units vs a transaction model
module tb_load_store_unit;
   logic clk = 1'b0, rst_n = 1'b0, preload = 1'b1, checking = 1'b0;
   always #5 clk = ~clk;
   logic        valid = 1'b0, we = 1'b0, uns = 1'b0;
   logic [1:0]  size = 2'b00;
   logic [31:0] addr = '0, wd = '0;
   logic [1:0]  ready, rv, re, mw;
   logic [31:0] rdata[2], maddr[2], mwd[2], mrd[2];
   logic [7:0]  mem[2][2048];
   logic [7:0]  refm[2][2048];
   int tests = 0, fails = 0, cyc = 0;
   int busy_lo[2], busy_hi[2], resp_cyc[2], wr_cyc[2];
   logic [31:0] exp_rd[2], exp_wd[2], exp_addr[2], last_rd[2];
   logic        exp_err[2], last_err[2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      load_store_unit #(.ALLOW_MISALIGNED(g == 0), .ADDR_W(32)) dut (
         .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(ready[g]),
         .req_we_i(we), .req_size_i(size), .req_unsigned_i(uns), .req_addr_i(addr),
         .req_wdata_i(wd), .resp_valid_o(rv[g]), .resp_rdata_o(rdata[g]), .resp_err_o(re[g]),
         .mem_data_addr_o(maddr[g]), .mem_data_wdata_o(mwd[g]), .mem_data_rdata_i(mrd[g]),
         .mem_write_o(mw[g])
      );
   end

   always_comb
      for (int i = 0; i < 2; i++)
         for (int k = 0; k < 4; k++)
            mrd[i][8*k +: 8] = mem[i][11'(maddr[i] + 32'(k))];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++)
         if (preload) for (int j = 0; j < 2048; j++) mem[i][j] <= refm[i][j];
         else if (mw[i]) for (int k = 0; k < 4; k++) mem[i][11'(maddr[i] + 32'(k))] <= mwd[i][8*k +: 8];
   end

   task automatic chk(input string n, input int i, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s[dut%0d] cycle %0d: got %h, expected %h", n, i, cyc, got, want);
      end
   endtask

   function automatic logic [31:0] word(input int i, input int a);
      return {mem[i][11'(a+3)], mem[i][11'(a+2)], mem[i][11'(a+1)], mem[i][11'(a)]};
   endfunction

   always @(negedge clk)
      if (rst_n && checking)
         for (int i = 0; i < 2; i++) begin
            chk("ready", i, 32'(ready[i]), 32'(!(cyc >= busy_lo[i] && cyc <= busy_hi[i])));
            chk("resp_valid", i, 32'(rv[i]), 32'(cyc == resp_cyc[i]));
            chk("mem_write", i, 32'(mw[i]), 32'(cyc == wr_cyc[i]));
            if (cyc == resp_cyc[i]) begin
               chk("resp_rdata", i, rdata[i], exp_rd[i]);
               chk("resp_err", i, 32'(re[i]), 32'(exp_err[i]));
               last_rd[i]  = rdata[i];
               last_err[i] = re[i];
            end
            if (cyc == wr_cyc[i]) begin
               chk("mem_addr", i, maddr[i], exp_addr[i]);
               chk("mem_wdata", i, mwd[i], exp_wd[i]);
            end
         end

   task automatic model(input int i, input int acc, input logic w, input logic [1:0] s,
                        input logic u, input logic [31:0] a, input logic [31:0] d);
      int n;
      logic [31:0] v;
      n = s == 2'd0 ? 1 : s == 2'd1 ? 2 : 4;
      exp_err[i] = s == 2'd3 || (i == 1 && a % n != 0);
      exp_rd[i] = '0;
      wr_cyc[i] = -1;
      busy_lo[i] = acc;
      if (exp_err[i]) resp_cyc[i] = acc;
      else if (!w) begin
         v = '0;
         for (int k = 0; k < n; k++) v = v | (32'(refm[i][11'(a + 32'(k))]) << (8*k));
         if (!u && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
         exp_rd[i] = v;
         resp_cyc[i] = acc + 1;
      end else begin
         for (int k = 0; k < n; k++) refm[i][11'(a + 32'(k))] = d[8*k +: 8];
         for (int k = 0; k < 4; k++) exp_wd[i][8*k +: 8] = refm[i][11'(a + 32'(k))];
         exp_addr[i] = a;
         wr_cyc[i] = n == 4 ? acc : acc + 1;
         resp_cyc[i] = wr_cyc[i] + 1;
      end
      busy_hi[i] = resp_cyc[i];
   endtask

   task automatic start(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d, output int acc);
      @(negedge clk);
      acc = cyc + 1;
      valid = 1'b1; we = w; size = s; uns = u; addr = a; wd = d;
      last_rd = '{32'hBAD0BAD0, 32'hBAD0BAD0};
      last_err = '{1'bx, 1'bx};
      for (int i = 0; i < 2; i++) model(i, acc, w, s, u, a, d);
      @(negedge clk);
      valid = 1'b0; we = ~w; size = ~s; uns = ~u; addr = ~a; wd = ~d;
   endtask

   task automatic xact(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
      int acc;
      start(w, s, u, a, d, acc);
      while (cyc <= busy_hi[0] || cyc <= busy_hi[1]) @(negedge clk);
   endtask

   task automatic reset_outputs(input string n);
      for (int i = 0; i < 2; i++) begin
         chk({n, "_ready"}, i, 32'(ready[i]), 32'd1);
         chk({n, "_valid"}, i, 32'(rv[i]), 32'd0);
         chk({n, "_rdata"}, i, rdata[i], 32'd0);
         chk({n, "_err"}, i, 32'(re[i]), 32'd0);
         chk({n, "_write"}, i, 32'(mw[i]), 32'd0);
         chk({n, "_addr"}, i, maddr[i], 32'd0);
         chk({n, "_wdata"}, i, mwd[i], 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1);
   end

   initial begin
      int acc;
      for (int i = 0; i < 2; i++) begin
         busy_lo[i] = 1; busy_hi[i] = 0; resp_cyc[i] = -1; wr_cyc[i] = -1;
         for (int j = 0; j < 2048; j++) refm[i][j] = 8'h00;
         refm[i][11'h100] = 8'h80;
         refm[i][11'h101] = 8'h11; refm[i][11'h102] = 8'h22;
         refm[i][11'h103] = 8'h33; refm[i][11'h104] = 8'h44;
         {refm[i][11'h203], refm[i][11'h202], refm[i][11'h201], refm[i][11'h200]} = 32'hAABBCCDD;
         {refm[i][11'h403], refm[i][11'h402], refm[i][11'h401], refm[i][11'h400]} = 32'h01020304;
      end
      repeat (3) @(negedge clk);
      reset_outputs("reset");
      preload = 1'b0;
      rst_n = 1'b1;
      checking = 1'b1;

      xact(1'b0, 2'd0, 1'b0, 32'h100, 0);
      chk("byte_signed", 0, last_rd[0], 32'hFFFFFF80);
      chk("byte_signed_model", 1, exp_rd[1], 32'hFFFFFF80);
      xact(1'b0, 2'd0, 1'b1, 32'h100, 0);
      chk("byte_unsigned", 0, last_rd[0], 32'h00000080);

      xact(1'b1, 2'd1, 1'b0, 32'h200, 32'h5A5A1234);
      chk("half_store_model", 0, exp_wd[0], 32'hAABB1234);
      xact(1'b0, 2'd2, 1'b0, 32'h200, 0);
      chk("half_store_reload", 0, last_rd[0], 32'hAABB1234);
      xact(1'b0, 2'd1, 1'b0, 32'h202, 0);
      chk("half_signed", 1, last_rd[1], 32'hFFFFAABB);
      xact(1'b0, 2'd1, 1'b1, 32'h202, 0);
      chk("half_unsigned", 0, last_rd[0], 32'h0000AABB);
      xact(1'b1, 2'd0, 1'b1, 32'h203, 32'h00000055);
      xact(1'b0, 2'd2, 1'b0, 32'h200, 0);
      chk("byte_store_reload", 0, last_rd[0], 32'h55BB1234);

      xact(1'b1, 2'd2, 1'b0, 32'h300, 32'hDEADBEEF);
      xact(1'b0, 2'd2, 1'b0, 32'h300, 0);
      chk("word_back_to_back", 1, last_rd[1], 32'hDEADBEEF);

      xact(1'b0, 2'd2, 1'b0, 32'h102, 0);
      chk("misaligned_strict_err", 1, 32'(last_err[1]), 32'd1);
      chk("misaligned_strict_rdata", 1, last_rd[1], 32'd0);
      chk("misaligned_allowed_err", 0, 32'(last_err[0]), 32'd0);
      xact(1'b0, 2'd2, 1'b0, 32'h101, 0);
      chk("misaligned_word_load", 0, last_rd[0], 32'h44332211);
      xact(1'b0, 2'd1, 1'b0, 32'h201, 0);
      chk("misaligned_half_strict", 1, 32'(last_err[1]), 32'd1);
      xact(1'b0, 2'd3, 1'b0, 32'h100, 0);
      chk("size11_err_allowed", 0, 32'(last_err[0]), 32'd1);
      chk("size11_err_strict", 1, 32'(last_err[1]), 32'd1);
      xact(1'b1, 2'd3, 1'b0, 32'h300, 32'h12345678);
      chk("size11_store_err", 0, 32'(last_err[0]), 32'd1);
      chk("size11_store_mem", 0, word(0, 32'h300), 32'hDEADBEEF);

      start(1'b1, 2'd0, 1'b0, 32'h400, 32'h000000FF, acc);
      while (cyc < acc) @(negedge clk);
      #2 rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         busy_lo[i] = 1; busy_hi[i] = 0; resp_cyc[i] = -1; wr_cyc[i] = -1;
         refm[i][11'h400] = 8'h04;
      end
      #1 reset_outputs("async_reset");
      repeat (2) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) chk("reset_no_write", i, 32'(mw[i]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("ready_after_reset", i, 32'(ready[i]), 32'd1);
         chk("mem_after_reset", i, word(i, 32'h400), 32'h01020304);
      end
      xact(1'b0, 2'd2, 1'b0, 32'h400, 0);
      chk("reload_after_reset", 0, last_rd[0], 32'h01020304);
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
